nor_truth_table_sweeper: RTL and testbench

Parametrised successor to the two-input NOR-built AND lab gate. It evaluates a selectable WIDTH-input logic function, built exclusively from 2-input NOR primitives, across every input combination under a start/done handshake. Each step is streamed out, and the complete truth table is captured in a register. It is the self-checking core for the next gate-implementation lab set and replaces per-vector hand-written stimulus.

---
 rtl/nor_sweep_pkg.sv | 31 +++
 rtl/nor_gate_eval.sv | 51 +++++
 rtl/nor_truth_table_sweeper.sv | 103 ++++++++++
 tb/tb_nor_truth_table_sweeper.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nor_sweep_pkg.sv
// Shared encodings for the NOR truth-table sweeper: function select codes, FSM states
// and the 2-input NOR primitive every gate function is built from.
package nor_sweep_pkg;

  localparam logic [2:0] MODE_AND   = 3'd0;
  localparam logic [2:0] MODE_OR    = 3'd1;
  localparam logic [2:0] MODE_NAND  = 3'd2;
  localparam logic [2:0] MODE_NOR   = 3'd3;
  localparam logic [2:0] MODE_XOR   = 3'd4;
  localparam logic [2:0] MODE_XNOR  = 3'd5;
  localparam logic [2:0] MODE_RSVD6 = 3'd6;
  localparam logic [2:0] MODE_RSVD7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // Classic four-NOR XNOR: the shared first-level NOR feeds both half terms.
  function automatic logic xnor2(input logic a, input logic b);
    logic n1;
    n1 = nor2(a, b);
    return nor2(nor2(a, n1), nor2(b, n1));
  endfunction

endpackage

// File: rtl/nor_gate_eval.sv
// Combinational WIDTH-input gate evaluator. Every function value is derived from
// 2-input NOR cells arranged as reduction chains; only the final select is a plain mux.
module nor_gate_eval
  import nor_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out
);

  logic [WIDTH-1:0] in_n;
  logic             and_r;
  logic             or_r;
  logic             xor_r;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
    assign in_n[gi] = nor2(in_vec[gi], in_vec[gi]);
  end

  // AND folds as NOR of inverted operands, OR as inverted NOR, XOR as inverted XNOR.
  always_comb begin
    logic t;
    t     = 1'b0;
    and_r = in_vec[0];
    or_r  = in_vec[0];
    xor_r = in_vec[0];
    for (int i = 1; i < WIDTH; i++) begin
      and_r = nor2(nor2(and_r, and_r), in_n[i]);
      t     = nor2(or_r, in_vec[i]);
      or_r  = nor2(t, t);
      t     = xnor2(xor_r, in_vec[i]);
      xor_r = nor2(t, t);
    end
  end

  always_comb begin
    out = 1'b0;
    case (mode)
      MODE_AND:  out = and_r;
      MODE_OR:   out = or_r;
      MODE_NAND: out = nor2(and_r, and_r);
      MODE_NOR:  out = nor2(or_r, or_r);
      MODE_XOR:  out = xor_r;
      MODE_XNOR: out = nor2(xor_r, xor_r);
      default:   out = 1'b0;
    endcase
  end

endmodule

// File: rtl/nor_truth_table_sweeper.sv
// Sweeps every WIDTH-bit input combination through the NOR-built evaluator under a
// start/done handshake, streaming each step and capturing the full truth table.
module nor_truth_table_sweeper
  import nor_sweep_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int TABLE_W = 2 ** WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         mode,
  output logic               busy,
  output logic               step_valid,
  output logic [WIDTH-1:0]   step_in,
  output logic               step_out,
  output logic               done,
  output logic [TABLE_W-1:0] truth_table
);

  localparam int CNT_W = WIDTH + 1;

  state_t             state_reg;
  logic [2:0]         mode_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               busy_reg;
  logic               step_valid_reg;
  logic [WIDTH-1:0]   step_in_reg;
  logic               step_out_reg;
  logic               done_reg;
  logic [TABLE_W-1:0] table_reg;

  logic [2:0]         eval_mode;
  logic [WIDTH-1:0]   eval_in;
  logic               eval_out;

  // Step 0 is registered on the accepting edge, so it must see the live mode input.
  assign eval_mode = (state_reg == IDLE) ? mode : mode_reg;
  assign eval_in   = count_reg[WIDTH-1:0];

  nor_gate_eval #(.WIDTH(WIDTH)) u_eval (
    .mode   (eval_mode),
    .in_vec (eval_in),
    .out    (eval_out)
  );

  // count_reg holds the index of the next step to present; it is zero whenever IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mode_reg       <= '0;
      count_reg      <= '0;
      busy_reg       <= 1'b0;
      step_valid_reg <= 1'b0;
      step_in_reg    <= '0;
      step_out_reg   <= 1'b0;
      done_reg       <= 1'b0;
      table_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= RUN;
            mode_reg       <= mode;
            table_reg      <= '0;
            busy_reg       <= 1'b1;
            step_valid_reg <= 1'b1;
            step_in_reg    <= eval_in;
            step_out_reg   <= eval_out;
            count_reg      <= CNT_W'(1);
          end
        end
        RUN: begin
          table_reg[step_in_reg] <= step_out_reg;
          if (count_reg == CNT_W'(TABLE_W)) begin
            state_reg      <= DONE;
            step_valid_reg <= 1'b0;
            done_reg       <= 1'b1;
          end else begin
            step_in_reg    <= eval_in;
            step_out_reg   <= eval_out;
            count_reg      <= count_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          count_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign step_valid  = step_valid_reg;
  assign step_in     = step_in_reg;
  assign step_out    = step_out_reg;
  assign done        = done_reg;
  assign truth_table = table_reg;

endmodule

// File: tb/tb_nor_truth_table_sweeper.sv
// Scoreboard bench: three sweepers (WIDTH 1, 2, 3) driven with directed and random
// sweeps; a negedge monitor pops expected steps and final tables as the DUTs emit them.
module tb_nor_truth_table_sweeper;

  typedef struct {
    bit is_done;
    int k;
    int out;
    int due;
    int tt;
  } exp_t;

  typedef struct {
    string name;
    int    u;
    int    act;
    int    exp;
  } dchk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_u [3];
  logic [2:0] mode_u  [3];
  logic       busy_u  [3];
  logic       sv_u    [3];
  logic       so_u    [3];
  logic       done_u  [3];
  logic [7:0] si_u    [3];
  logic [7:0] tt_u    [3];

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q [3][$];
  dchk_t dchk_q[$];
  exp_t  mon_e;
  dchk_t mon_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [gi:0]          si;
    logic [(2<<gi)-1:0]   tt;
    nor_truth_table_sweeper #(.WIDTH(gi + 1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_u[gi]),
      .mode        (mode_u[gi]),
      .busy        (busy_u[gi]),
      .step_valid  (sv_u[gi]),
      .step_in     (si),
      .step_out    (so_u[gi]),
      .done        (done_u[gi]),
      .truth_table (tt)
    );
    assign si_u[gi] = 8'(si);
    assign tt_u[gi] = 8'(tt);
  end

  // Reference: functions defined by popcount over the input index.
  function automatic int ref_f(input int m, input int k, input int w);
    int ones;
    ones = $countones(k);
    case (m)
      0: return (ones == w) ? 1 : 0;
      1: return (k != 0) ? 1 : 0;
      2: return (ones == w) ? 0 : 1;
      3: return (k != 0) ? 0 : 1;
      4: return ones % 2;
      5: return 1 - (ones % 2);
      default: return 0;
    endcase
  endfunction

  function automatic int ref_table(input int m, input int w);
    int t;
    t = 0;
    for (int k = 0; k < (1 << w); k++) t = t | (ref_f(m, k, w) << k);
    return t;
  endfunction

  function automatic void dchk(input string n, input int u, input int a, input int e);
    dchk_q.push_back('{n, u, a, e});
  endfunction

  task automatic chk(input string name, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s unit%0d: got %0d expected %0d (cycle %0d)", name, u, act, exp, cyc);
    end
  endtask

  // Monitor: drains deferred driver checks and scores every DUT output event.
  always @(negedge clk) begin
    while (dchk_q.size() > 0) begin
      mon_d = dchk_q.pop_front();
      chk(mon_d.name, mon_d.u, mon_d.act, mon_d.exp);
    end
    if (rst_n === 1'b1) begin
      for (int u = 0; u < 3; u++) begin
        if (sv_u[u] === 1'b1) begin
          if (exp_q[u].size() == 0) begin
            chk("unexpected_step", u, 1, 0);
          end else begin
            mon_e = exp_q[u].pop_front();
            chk("step_kind", u, int'(mon_e.is_done), 0);
            chk("step_in", u, int'(si_u[u]), mon_e.k);
            chk("step_out", u, int'(so_u[u]), mon_e.out);
            chk("step_cycle", u, cyc, mon_e.due);
            chk("busy_in_run", u, int'(busy_u[u]), 1);
          end
        end
        if (done_u[u] === 1'b1) begin
          chk("done_excl_valid", u, int'(sv_u[u]), 0);
          if (exp_q[u].size() == 0) begin
            chk("unexpected_done", u, 1, 0);
          end else begin
            mon_e = exp_q[u].pop_front();
            chk("done_kind", u, int'(mon_e.is_done), 1);
            chk("truth_table", u, int'(tt_u[u]), mon_e.tt);
            chk("done_cycle", u, cyc, mon_e.due);
          end
        end
      end
    end
  end

  // One complete sweep; exp_tt >= 0 adds a check against a hand-written table constant.
  task automatic run_sweep(input int u, input int m, input bit hold, input int exp_tt);
    int w, tw, c0;
    bit got;
    w  = u + 1;
    tw = 1 << w;
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < tw; k++) exp_q[u].push_back('{0, k, ref_f(m, k, w), c0 + k, 0});
    exp_q[u].push_back('{1, 0, 0, c0 + tw, ref_table(m, w)});
    start_u[u] = 1'b1;
    mode_u[u]  = 3'(m);
    @(negedge clk);
    if (!hold) start_u[u] = 1'b0;
    got = 0;
    for (int i = 0; i < tw + 8 && !got; i++) begin
      mode_u[u] = 3'($urandom_range(0, 7));
      if (done_u[u] === 1'b1) got = 1;
      else @(negedge clk);
    end
    start_u[u] = 1'b0;
    dchk("done_seen", u, int'(got), 1);
    if (exp_tt >= 0) dchk("plan_table", u, int'(tt_u[u]), exp_tt);
    dchk("busy_in_done", u, int'(busy_u[u]), 1);
    @(negedge clk);
    dchk("busy_after", u, int'(busy_u[u]), 0);
    dchk("valid_after", u, int'(sv_u[u]), 0);
    $display("sweep unit%0d width=%0d mode=%0d hold=%0d table=0x%0h", u, w, m, hold, tt_u[u]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_u[u] = 1'b0;
      mode_u[u]  = 3'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      dchk("rst_busy", u, int'(busy_u[u]), 0);
      dchk("rst_valid", u, int'(sv_u[u]), 0);
      dchk("rst_step_in", u, int'(si_u[u]), 0);
      dchk("rst_step_out", u, int'(so_u[u]), 0);
      dchk("rst_done", u, int'(done_u[u]), 0);
      dchk("rst_table", u, int'(tt_u[u]), 0);
    end
    rst_n = 1'b1;

    run_sweep(1, 0, 0, 'h8);
    run_sweep(1, 4, 0, 'h6);
    run_sweep(1, 5, 0, 'h9);
    run_sweep(2, 3, 0, 'h01);
    run_sweep(2, 2, 0, 'h7f);
    run_sweep(1, 1, 1, 'he);
    run_sweep(0, 2, 0, 'h1);
    run_sweep(0, 0, 0, 'h2);
    run_sweep(0, 4, 1, 'h2);

    // Abort a WIDTH=3 AND sweep right after step 3 with a one-edge reset.
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 8; k++) exp_q[2].push_back('{0, k, ref_f(0, k, 3), c0 + k, 0});
    start_u[2] = 1'b1;
    mode_u[2]  = 3'd0;
    @(negedge clk);
    start_u[2] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q[2].delete();
    @(negedge clk);
    dchk("abort_busy", 2, int'(busy_u[2]), 0);
    dchk("abort_table", 2, int'(tt_u[2]), 0);
    dchk("abort_valid", 2, int'(sv_u[2]), 0);
    dchk("abort_done", 2, int'(done_u[2]), 0);
    rst_n = 1'b1;
    $display("abort unit2 busy=%0d table=0x%0h", busy_u[2], tt_u[2]);
    run_sweep(2, 7, 0, 'h00);

    for (int n = 0; n < 24; n++) begin
      run_sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), -1);
    end

    for (int u = 0; u < 3; u++) dchk("queue_drained", u, exp_q[u].size(), 0);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
